// File: rtl/histo_if.sv
// Pixel stream and histogram SRAM port bundle for histo_build.
interface histo_if #(
    parameter int unsigned p_depth_bit        = 8,
    parameter int unsigned p_histo_sram_d_bit = 10
);
    logic                          pix_valid;
    logic                          pix_ready;
    logic [p_depth_bit-1:0]        pix_data;
    logic                          pix_last;
    logic                          sram_re;
    logic [p_depth_bit-1:0]        sram_ra;
    logic [p_histo_sram_d_bit-1:0] sram_rd;
    logic                          sram_we;
    logic [p_depth_bit-1:0]        sram_wa;
    logic [p_histo_sram_d_bit-1:0] sram_wd;

    modport slave (
        input  pix_valid, pix_data, pix_last, sram_rd,
        output pix_ready, sram_re, sram_ra, sram_we, sram_wa, sram_wd
    );

    modport master (
        output pix_valid, pix_data, pix_last, sram_rd,
        input  pix_ready, sram_re, sram_ra, sram_we, sram_wa, sram_wd
    );
endinterface

// File: rtl/histo_build.sv
// Frame histogram builder: clears the bin SRAM, then read-modify-writes one bin per
// accepted pixel with a one-deep forward to cover back-to-back hits on the same bin.
module histo_build #(
    parameter int unsigned p_depth_bit        = 8,
    parameter int unsigned p_histo_sram_d_bit = 10,
    parameter int unsigned p_histo_size       = 2**p_depth_bit
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    start,
    histo_if.slave  bus,
    output logic    busy,
    output logic    done,
    output logic    sat
);
    localparam int unsigned aw = p_depth_bit;
    localparam int unsigned dw = p_histo_sram_d_bit;
    localparam logic [aw-1:0] clr_last = aw'(p_histo_size - 1);
    localparam logic [dw-1:0] cnt_max  = '1;

    typedef enum logic [2:0] {
        st_idle, st_clear, st_accum, st_drain, st_done
    } state_t;

    state_t          state, state_nxt;
    logic [aw-1:0]   clr_cnt;
    logic            s1_valid;
    logic [aw-1:0]   s1_addr;
    logic            pw_valid;
    logic [aw-1:0]   pw_addr;
    logic [dw-1:0]   pw_data;
    logic            accept;
    logic            clearing;
    logic [dw-1:0]   base;
    logic            hit_max;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= st_idle;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            st_idle:  if (start) state_nxt = st_clear;
            st_clear: if (clr_cnt == clr_last) state_nxt = st_accum;
            st_accum: if (accept && bus.pix_last) state_nxt = st_drain;
            st_drain: state_nxt = st_done;
            st_done:  state_nxt = st_idle;
            default:  state_nxt = st_idle;
        endcase
    end

    assign bus.pix_ready = (state == st_accum);
    assign busy          = (state != st_idle);
    assign done          = (state == st_done);
    assign clearing      = (state == st_clear);
    assign accept        = bus.pix_valid & bus.pix_ready;

    // Read is issued in the acceptance cycle so data returns in time for the write
    assign bus.sram_re = accept;
    assign bus.sram_ra = accept ? bus.pix_data : '0;

    // SRAM returns pre-write data on a read-during-write, so take the previous write instead
    assign base    = (pw_valid && pw_addr == s1_addr) ? pw_data : bus.sram_rd;
    assign hit_max = s1_valid && (base == cnt_max);

    // Write port mux: clear sweep or increment stage
    always_comb begin
        bus.sram_we = 1'b0;
        bus.sram_wa = '0;
        bus.sram_wd = '0;
        if (clearing) begin
            bus.sram_we = 1'b1;
            bus.sram_wa = clr_cnt;
        end else if (s1_valid) begin
            bus.sram_we = 1'b1;
            bus.sram_wa = s1_addr;
            bus.sram_wd = hit_max ? base : base + dw'(1);
        end
    end

    // Clear address counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                     clr_cnt <= '0;
        else if (clearing && state_nxt == st_clear)     clr_cnt <= clr_cnt + aw'(1);
        else                                            clr_cnt <= '0;
    end

    // Increment stage and last-write record for forwarding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            pw_valid <= 1'b0;
            pw_addr  <= '0;
            pw_data  <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) s1_addr <= bus.pix_data;
            pw_valid <= bus.sram_we;
            pw_addr  <= bus.sram_wa;
            pw_data  <= bus.sram_wd;
        end
    end

    // Sticky saturation flag, cleared when a new frame starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         sat <= 1'b0;
        else if (state == st_idle && start) sat <= 1'b0;
        else if (hit_max)                   sat <= 1'b1;
    end
endmodule

// File: tb/tb_histo_build.sv
// Randomized self-checking bench for histo_build with a behavioural SRAM and bin-count model.
module tb_histo_build;
    localparam int unsigned aw    = 8;
    localparam int unsigned dw    = 10;
    localparam int          nbins = 256;
    localparam int          maxc  = 1023;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy, done, sat;

    histo_if #(.p_depth_bit(aw), .p_histo_sram_d_bit(dw)) bus ();

    histo_build #(.p_depth_bit(aw), .p_histo_sram_d_bit(dw)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bus   (bus.slave),
        .busy  (busy),
        .done  (done),
        .sat   (sat)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM: read-during-write returns old data; writes are logged
    logic [dw-1:0] mem [nbins];
    logic          preload_en  = 1'b0;
    logic [dw-1:0] preload_val = '0;
    int            cyc = 0;
    int            wlog_a[$];
    int            wlog_d[$];
    int            wlog_c[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (preload_en) begin
            for (int i = 0; i < nbins; i++) mem[i] <= preload_val;
        end else if (bus.sram_we) begin
            mem[bus.sram_wa] <= bus.sram_wd;
            wlog_a.push_back(int'(bus.sram_wa));
            wlog_d.push_back(int'(bus.sram_wd));
            wlog_c.push_back(cyc);
        end
        if (bus.sram_re) bus.sram_rd <= mem[bus.sram_ra];
    end

    int checks   = 0;
    int failures = 0;
    int model[nbins];
    bit sat_exp;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, int'({bus.pix_ready, bus.sram_re, bus.sram_we, busy, done, sat}), 0);
        check({tag, "_ra"}, int'(bus.sram_ra), 0);
        check({tag, "_wa_wd"}, int'({bus.sram_wa, bus.sram_wd}), 0);
    endtask

    // Full frame: preload, start, verify clear sweep, stream pixels, verify done and bins
    task automatic do_frame(input string tag, input int pix[$], input int gap_pct,
                            input logic [dw-1:0] pre, input bit poke_start, output int mark);
        int n, bad, not_ready, gaps;
        @(negedge clk);
        preload_val = pre;
        preload_en  = 1'b1;
        @(negedge clk);
        preload_en  = 1'b0;
        for (int i = 0; i < nbins; i++) model[i] = 0;
        sat_exp = 1'b0;
        mark = wlog_a.size();

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!bus.pix_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_clr_latency"}, n, 257);
        bad = 0;
        if (wlog_a.size() < mark + nbins) bad = nbins;
        else for (int i = 0; i < nbins; i++)
            if (wlog_a[mark + i] != i || wlog_d[mark + i] != 0) bad++;
        check({tag, "_clr_writes_bad"}, bad, 0);

        not_ready = 0;
        for (int k = 0; k < pix.size(); k++) begin
            gaps = 0;
            while (gap_pct > 0 && gaps < 3 && $urandom_range(99, 0) < gap_pct) begin
                bus.pix_valid = 1'b0;
                bus.pix_data  = aw'($urandom);
                @(negedge clk);
                gaps++;
            end
            bus.pix_valid = 1'b1;
            bus.pix_data  = aw'(pix[k]);
            bus.pix_last  = (k == pix.size() - 1);
            if (poke_start && k == pix.size() / 2) start = 1'b1;
            if (!bus.pix_ready) not_ready++;
            @(negedge clk);
            start = 1'b0;
            if (model[pix[k]] == maxc) sat_exp = 1'b1;
            else model[pix[k]]++;
        end
        bus.pix_valid = 1'b0;
        bus.pix_last  = 1'b0;
        check({tag, "_not_ready"}, not_ready, 0);
        check({tag, "_ready_drop"}, int'(bus.pix_ready), 0);

        n = 1;
        while (!done && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_latency"}, n, 2);
        @(negedge clk);
        check({tag, "_done_pulse_idle"}, int'({done, busy}), 0);

        bad = 0;
        for (int i = 0; i < nbins; i++) if (int'(mem[i]) != model[i]) bad++;
        check({tag, "_bins_bad"}, bad, 0);
        check({tag, "_sat"}, int'(sat), int'(sat_exp));
    endtask

    initial begin
        int pix[$];
        int mark, n, wsz;
        bus.pix_valid = 1'b0;
        bus.pix_data  = '0;
        bus.pix_last  = 1'b0;

        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", int'(busy), 0);

        // Distinct values 0..9 over a fully-set SRAM
        pix.delete();
        for (int i = 0; i < 10; i++) pix.push_back(i);
        do_frame("distinct", pix, 0, 10'h3FF, 1'b0, mark);
        check("distinct_bin9", int'(mem[9]), 1);
        check("distinct_bin10", int'(mem[10]), 0);

        // Back-to-back hits on one bin
        pix.delete();
        repeat (5) pix.push_back(8'h7F);
        do_frame("hazard", pix, 0, 10'h3FF, 1'b0, mark);
        check("hazard_bin", int'(mem[127]), 5);
        n = 0;
        if (wlog_d.size() < mark + 261) n = 99;
        else for (int i = 0; i < 5; i++)
            if (wlog_d[mark + 256 + i] != i + 1 || wlog_a[mark + 256 + i] != 127) n++;
        check("hazard_wd_seq_bad", n, 0);
        if (wlog_c.size() >= mark + 261)
            check("hazard_write_span", wlog_c[mark + 260] - wlog_c[mark + 256], 4);
        else
            check("hazard_write_span", -1, 4);

        // Saturation on bin 0
        pix.delete();
        repeat (1030) pix.push_back(0);
        do_frame("satur", pix, 0, 10'h000, 1'b0, mark);
        check("satur_bin0", int'(mem[0]), 1023);
        check("satur_flag", int'(sat), 1);

        // Exactly full count does not saturate
        pix.delete();
        repeat (1023) pix.push_back(8'hFF);
        do_frame("full", pix, 0, 10'h155, 1'b0, mark);
        check("full_bin255", int'(mem[255]), 1023);

        // Single-pixel frame
        pix.delete();
        pix.push_back(8'hFF);
        do_frame("single", pix, 0, 10'h2AA, 1'b0, mark);

        // Random clustered stream, gapless then with gaps and an ignored start
        pix.delete();
        n = $urandom_range(200, 60);
        for (int i = 0; i < n; i++) pix.push_back($urandom_range(15, 0));
        do_frame("rand_gapless", pix, 0, 10'h3FF, 1'b0, mark);
        do_frame("rand_gaps", pix, 40, 10'h3FF, 1'b1, mark);

        pix.delete();
        n = $urandom_range(150, 20);
        for (int i = 0; i < n; i++) pix.push_back($urandom_range(255, 0));
        do_frame("rand_wide", pix, 25, 10'h0F0, 1'b0, mark);

        // Reset in the middle of ACCUM
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!bus.pix_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 3; i++) begin
            bus.pix_valid = 1'b1;
            bus.pix_data  = 8'h21;
            @(negedge clk);
        end
        bus.pix_data = 8'h5A;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        wsz = wlog_a.size();
        @(posedge clk);
        #1;
        check("midrst_no_write", wlog_a.size(), wsz);
        @(negedge clk);
        bus.pix_valid = 1'b0;
        rst_n = 1'b1;

        pix.delete();
        for (int i = 0; i < 40; i++) pix.push_back($urandom_range(7, 0));
        do_frame("after_rst", pix, 20, 10'h3FF, 1'b0, mark);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/histo_build.md
HISTO_BUILD -- requirements
Module: histo_build

Interface
REQ-001 The block SHALL have parameter p_depth_bit, default 8, input pixel width and histo SRAM address width.
REQ-002 The block SHALL have parameter p_histo_sram_d_bit, default 10, histo bin count width.
REQ-003 The block SHALL have parameter p_histo_size, default 2**p_depth_bit, number of histo bins.
REQ-004 The block SHALL have port clk, in, 1, single clock; all logic on rising edge.
REQ-005 The block SHALL have port rst_n, in, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port start, in, 1, one-cycle pulse that begins a new frame histogram.
REQ-007 The block SHALL have port pix_valid, in, 1, input pixel valid.
REQ-008 The block SHALL have port pix_ready, out, 1, block accepts a pixel this cycle.
REQ-009 The block SHALL have port pix_data, in, p_depth_bit, pixel value.
REQ-010 The block SHALL have port pix_last, in, 1, marks the last pixel of the frame.
REQ-011 The block SHALL have port sram_re, out, 1, histo SRAM read enable.
REQ-012 The block SHALL have port sram_ra, out, p_depth_bit, histo SRAM read address.
REQ-013 The block SHALL have port sram_rd, in, p_histo_sram_d_bit, read data, valid one cycle after sram_re.
REQ-014 The block SHALL have port sram_we, out, 1, histo SRAM write enable.
REQ-015 The block SHALL have port sram_wa, out, p_depth_bit, histo SRAM write address.
REQ-016 The block SHALL have port sram_wd, out, p_histo_sram_d_bit, histo SRAM write data.
REQ-017 The block SHALL have port busy, out, 1, high in every state except IDLE.
REQ-018 The block SHALL have port done, out, 1, one-cycle pulse when the histogram is complete in SRAM.
REQ-019 The block SHALL have port sat, out, 1, sticky flag: at least one bin saturated this frame.

Function
REQ-020 The block SHALL implement FSM states IDLE, CLEAR, ACCUM, DRAIN, DONE.
REQ-021 In IDLE, start SHALL move the FSM to CLEAR and clear sat; start in any other state SHALL be ignored.
REQ-022 CLEAR SHALL write 0 to addresses 0..p_histo_size-1 in ascending order, one per cycle (256 cycles), then enter ACCUM.
REQ-023 pix_ready SHALL be 1 only in ACCUM; a pixel is accepted when pix_valid and pix_ready are both 1.
REQ-024 On acceptance in cycle t, sram_re=1 and sram_ra=pix_data in cycle t.
REQ-025 In cycle t+1, sram_we=1, sram_wa=address accepted in cycle t, and sram_wd=base+1 (saturating).
REQ-026 base SHALL be sram_rd, except when the address in stage t+1 equals the address written in cycle t; then base SHALL be the value written in cycle t (forwarding; SRAM read-during-write returns old data).
REQ-027 Throughput SHALL be one pixel per cycle with no bubbles, including runs of identical pixel values.
REQ-028 If base equals 2**p_histo_sram_d_bit-1, sram_wd SHALL stay at that value and sat SHALL be set.
REQ-029 Acceptance of a pixel with pix_last=1 SHALL move the FSM to DRAIN; pix_ready SHALL drop in the following cycle.
REQ-030 DRAIN SHALL last one cycle, during which the final write is issued; the FSM then enters DONE.
REQ-031 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-032 A frame SHALL contain at least one pixel; pix_valid with pix_ready=0 SHALL have no effect.
REQ-033 sram_re and sram_we SHALL never be asserted outside CLEAR, ACCUM, and DRAIN; sram_re SHALL be 0 in CLEAR.

Reset
REQ-034 When rst_n=0, the block SHALL asynchronously force FSM=IDLE, clear pipeline valids, and drive pix_ready=0, sram_re=0, sram_we=0, busy=0, done=0, sat=0, with all address and data outputs at 0.
REQ-035 Reset mid-frame SHALL abort the frame without issuing a further SRAM write; SRAM contents are not restored, and the next start re-clears them.

Verification
REQ-036 Clear: start, then SRAM model preloaded with 0x3FF -> 256 writes of 0 to addresses 0..255, then pix_ready=1 at cycle 257.
REQ-037 Distinct pixels: frame 0,1,2,...,9 with last on 9 -> bins 0..9 equal 1, all others 0, done 2 cycles after the last acceptance.
REQ-038 Hazard: 5 back-to-back pixels of value 0x7F -> bin 127 equals 5, one write per cycle with wd 1,2,3,4,5.
REQ-039 Saturation: 1030 pixels of value 0x00 -> bin 0 equals 1023, sat=1, other bins 0.
REQ-040 Backpressure and reset: gaps in pix_valid give the same histogram as a gapless stream; rst_n low mid-ACCUM -> all outputs return to their reset values within the same cycle, and the next start begins with CLEAR.
